keypad_scanner: RTL and testbench

Matrix keypad column driver and key encoder for the 4x4 keypad front end. It drives one active-low column at a time and reads the four row lines, which arrive as clean levels from the row debouncers. It holds the column while a press is qualified, then emits a 4-bit key code with a one-cycle valid strobe. It waits for release before scanning resumes, so each physical press yields exactly one key event.

---
 rtl/keypad_if.sv | 11 +
 rtl/keypad_scanner.sv | 118 +++++++++++
 tb/tb_keypad_scanner.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/keypad_if.sv
// Keypad front-end bundle: row levels in, active-low column drive and key event outputs.
interface keypad_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (output row, input col, key_code, key_valid, key_held);
    modport slave  (input row, output col, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, qualifies a stable row
// pattern into one key event, then waits for a qualified release before resuming.
module keypad_scanner #(
    parameter int SCAN_CYCLES    = 5,
    parameter int RELEASE_CYCLES = 5
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.slave  kp
);
    typedef enum logic [1:0] {SCAN, DETECT, PRESSED} state_t;

    localparam logic [7:0] SC_LAST = 8'(SCAN_CYCLES - 1);
    localparam logic [7:0] RC_LAST = 8'(RELEASE_CYCLES - 1);

    state_t     state_q;
    logic [3:0] col_q;
    logic [3:0] row_ref_q;
    logic [3:0] key_code_q;
    logic       key_valid_q;
    logic       key_held_q;
    logic [7:0] dwell_q;
    logic [7:0] match_q;
    logic [7:0] rel_q;
    logic [3:0] acc_row;
    logic [3:0] acc_code;

    function automatic logic [1:0] low_idx(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // With SCAN_CYCLES=1 the press is accepted straight from SCAN using the live rows.
    always_comb begin
        acc_row  = (state_q == SCAN) ? kp.row : row_ref_q;
        acc_code = {low_idx(acc_row), low_idx(~col_q)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            col_q       <= 4'b1110;
            row_ref_q   <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            dwell_q     <= 8'd0;
            match_q     <= 8'd0;
            rel_q       <= 8'd0;
        end else begin
            key_valid_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (kp.row == 4'd0) begin
                        if (dwell_q == SC_LAST) begin
                            col_q   <= {col_q[2:0], col_q[3]};
                            dwell_q <= 8'd0;
                        end else begin
                            dwell_q <= dwell_q + 8'd1;
                        end
                    end else if (SCAN_CYCLES == 1) begin
                        key_code_q  <= acc_code;
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        dwell_q     <= 8'd0;
                        rel_q       <= 8'd0;
                        state_q     <= PRESSED;
                    end else begin
                        row_ref_q <= kp.row;
                        match_q   <= 8'd1;
                        dwell_q   <= 8'd0;
                        state_q   <= DETECT;
                    end
                end
                DETECT: begin
                    if (kp.row == row_ref_q) begin
                        if (match_q == SC_LAST) begin
                            key_code_q  <= acc_code;
                            key_valid_q <= 1'b1;
                            key_held_q  <= 1'b1;
                            rel_q       <= 8'd0;
                            state_q     <= PRESSED;
                        end else begin
                            match_q <= match_q + 8'd1;
                        end
                    end else begin
                        dwell_q <= 8'd0;
                        match_q <= 8'd0;
                        state_q <= SCAN;
                    end
                end
                PRESSED: begin
                    // Any non-zero sample is release bounce: restart the release count.
                    if (kp.row != 4'd0) begin
                        rel_q <= 8'd0;
                    end else if (rel_q == RC_LAST) begin
                        key_held_q <= 1'b0;
                        col_q      <= {col_q[2:0], col_q[3]};
                        dwell_q    <= 8'd0;
                        match_q    <= 8'd0;
                        rel_q      <= 8'd0;
                        state_q    <= SCAN;
                    end else begin
                        rel_q <= rel_q + 8'd1;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign kp.col       = col_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: expected key codes are queued at stimulus time
// and matched against each key_valid pulse; scan/press/release timing checked inline.
module tb_keypad_scanner;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   n_valid;
    logic [3:0] exp_q[$];
    logic [3:0] colpat [4];

    keypad_if kp();

    keypad_scanner #(.SCAN_CYCLES(5), .RELEASE_CYCLES(5)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Output monitor: every key_valid pulse must match the oldest queued key.
    always @(negedge clk) begin
        if (kp.key_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(kp.key_code), 32'hFF);
            end else begin
                chk("sb_key_code", 32'(kp.key_code), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_valid  = 0;
        colpat   = '{4'hE, 4'hD, 4'hB, 4'h7};
        rst      = 1'b1;
        kp.row   = 4'd0;
        tick();
        tick();
        chk("rst_col", 32'(kp.col), 32'hE);
        chk("rst_code", 32'(kp.key_code), 32'h0);
        chk("rst_valid", 32'(kp.key_valid), 32'h0);
        chk("rst_held", 32'(kp.key_held), 32'h0);
        rst = 1'b0;

        // Idle sweep with wrap
        for (int i = 0; i < 25; i++) begin
            chk("idle_col", 32'(kp.col), 32'(colpat[(i / 5) % 4]));
            chk("idle_held", 32'(kp.key_held), 32'h0);
            tick();
        end
        chk("idle_code", 32'(kp.key_code), 32'h0);
        chk("idle_col_start_press", 32'(kp.col), 32'hD);

        // Press row 2 on column 1 -> key 9
        kp.row = 4'b0100;
        exp_q.push_back(4'd9);
        for (int j = 0; j < 20; j++) begin
            tick();
            chk("press_valid", 32'(kp.key_valid), 32'(j == 4));
            chk("press_held", 32'(kp.key_held), 32'(j >= 4));
            chk("press_col", 32'(kp.col), 32'hD);
        end
        chk("press_code", 32'(kp.key_code), 32'h9);

        // Release with one bounce sample
        kp.row = 4'd0;
        repeat (3) tick();
        kp.row = 4'b0100;
        tick();
        chk("bounce_held", 32'(kp.key_held), 32'h1);
        kp.row = 4'd0;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("rel_held", 32'(kp.key_held), 32'(k < 4));
            chk("rel_col", 32'(kp.col), (k < 4) ? 32'hD : 32'hB);
        end
        tick();
        chk("col3_reached", 32'(kp.col), 32'h7);

        // Two rows on column 3: lowest row wins -> key 7
        kp.row = 4'b1010;
        exp_q.push_back(4'd7);
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("multi_valid", 32'(kp.key_valid), 32'(j == 4));
        end
        chk("multi_code", 32'(kp.key_code), 32'h7);
        kp.row = 4'd0;
        repeat (5) tick();
        chk("multi_rel_held", 32'(kp.key_held), 32'h0);
        chk("multi_rel_col", 32'(kp.col), 32'hE);

        // Short glitch on column 0 is rejected
        kp.row = 4'b0010;
        repeat (3) tick();
        kp.row = 4'd0;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk("glitch_col", 32'(kp.col), (k < 5) ? 32'hE : 32'hD);
            chk("glitch_code", 32'(kp.key_code), 32'h7);
            if (k < 5) tick();
        end

        // Press on column 1 row 0 -> key 1, then asynchronous reset while held
        kp.row = 4'b0001;
        exp_q.push_back(4'd1);
        repeat (5) tick();
        chk("pre_rst_held", 32'(kp.key_held), 32'h1);
        chk("pre_rst_code", 32'(kp.key_code), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_col", 32'(kp.col), 32'hE);
        chk("arst_held", 32'(kp.key_held), 32'h0);
        chk("arst_code", 32'(kp.key_code), 32'h0);
        chk("arst_valid", 32'(kp.key_valid), 32'h0);
        kp.row = 4'd0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("resume_col0", 32'(kp.col), 32'hE);
        tick();
        chk("resume_col1", 32'(kp.col), 32'hD);

        tick();
        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        chk("valid_count", 32'(n_valid), 32'h3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
